// File: rtl/frog_btn_conditioner.sv
// Turns four raw active-low direction keys into one-shot active-low hop requests for the frog.
// Latency: 2 sync + DB_CYCLES debounce + 1 clk from key press to registered request.
// Backpressure: a request holds until an animation tick consumes it; presses arriving meanwhile are dropped.
module frog_btn_conditioner #(
    parameter int DB_CYCLES    = 500000,
    parameter int REPEAT_TICKS = 24
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_ani_stb,
    input  logic i_animate,
    input  logic i_dead,
    input  logic i_up_n,
    input  logic i_down_n,
    input  logic i_left_n,
    input  logic i_right_n,
    output logic o_up_btn,
    output logic o_down_btn,
    output logic o_left_btn,
    output logic o_right_btn
);

    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int RP_W = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_TICKS - 1);
    localparam bit REP_EN = (REPEAT_TICKS != 0);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // bit order everywhere: [0]=up, [1]=down, [2]=left, [3]=right
    logic            tick;
    logic [3:0]      key_raw;
    logic [3:0]      sync_a;
    logic [3:0]      sync_b;
    logic [3:0]      db_lvl;
    logic [3:0]      db_prev;
    logic [3:0]      press;
    logic [3:0][DB_W-1:0] db_cnt;

    logic            press_any;
    logic [1:0]      press_key;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      req_key;
    logic [1:0]      key_nxt;
    logic [RP_W-1:0] rep_cnt;
    logic [RP_W-1:0] rep_nxt;
    logic [3:0]      out_n;
    logic [3:0]      out_nxt;

    assign tick    = i_animate & i_ani_stb;
    assign key_raw = {i_right_n, i_left_n, i_down_n, i_up_n};
    assign press   = db_prev & ~db_lvl;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_a  <= '1;
            sync_b  <= '1;
            db_lvl  <= '1;
            db_prev <= '1;
            db_cnt  <= '0;
        end else begin
            sync_a  <= key_raw;
            sync_b  <= sync_a;
            db_prev <= db_lvl;
            for (int i = 0; i < 4; i++) begin
                if (sync_b[i] != db_lvl[i]) begin
                    // counter clears on the level flip, so it can never pass DB_LAST
                    if (db_cnt[i] == DB_LAST) begin
                        db_lvl[i] <= sync_b[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        press_any = |press;
        press_key = 2'd0;
        if (press[0]) begin
            press_key = 2'd0;
        end else if (press[1]) begin
            press_key = 2'd1;
        end else if (press[2]) begin
            press_key = 2'd2;
        end else if (press[3]) begin
            press_key = 2'd3;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            req_key <= 2'd0;
            rep_cnt <= '0;
            out_n   <= '1;
        end else begin
            state   <= state_nxt;
            req_key <= key_nxt;
            rep_cnt <= rep_nxt;
            out_n   <= out_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        key_nxt   = req_key;
        rep_nxt   = rep_cnt;
        out_nxt   = 4'b1111;
        if (i_dead) begin
            state_nxt = IDLE;
            rep_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press_any) begin
                        state_nxt = REQ;
                        key_nxt   = press_key;
                        rep_nxt   = '0;
                    end else if (REP_EN && !db_lvl[req_key]) begin
                        // auto-repeat only counts ticks while the last requested key stays held
                        if (tick) begin
                            if (rep_cnt == RP_LAST) begin
                                state_nxt = REQ;
                                rep_nxt   = '0;
                            end else begin
                                rep_nxt = rep_cnt + RP_W'(1);
                            end
                        end
                    end else begin
                        rep_nxt = '0;
                    end
                end
                REQ: begin
                    if (tick) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
        if (state_nxt == REQ) begin
            out_nxt[key_nxt] = 1'b0;
        end
    end

    assign o_up_btn    = out_n[0];
    assign o_down_btn  = out_n[1];
    assign o_left_btn  = out_n[2];
    assign o_right_btn = out_n[3];

endmodule

// File: tb/tb_frog_btn_conditioner.sv
// Directed bench for frog_btn_conditioner with DB_CYCLES=4, REPEAT_TICKS=3, i_animate held high.
module tb_frog_btn_conditioner;

    logic i_clk     = 1'b0;
    logic i_rst     = 1'b1;
    logic i_ani_stb = 1'b0;
    logic i_animate = 1'b1;
    logic i_dead    = 1'b0;
    logic i_up_n    = 1'b1;
    logic i_down_n  = 1'b1;
    logic i_left_n  = 1'b1;
    logic i_right_n = 1'b1;
    logic o_up_btn;
    logic o_down_btn;
    logic o_left_btn;
    logic o_right_btn;
    logic [3:0] outs;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cons [4];
    logic [3:0] low_seen;
    int         multi = 0;

    frog_btn_conditioner #(
        .DB_CYCLES   (4),
        .REPEAT_TICKS(3)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ani_stb  (i_ani_stb),
        .i_animate  (i_animate),
        .i_dead     (i_dead),
        .i_up_n     (i_up_n),
        .i_down_n   (i_down_n),
        .i_left_n   (i_left_n),
        .i_right_n  (i_right_n),
        .o_up_btn   (o_up_btn),
        .o_down_btn (o_down_btn),
        .o_left_btn (o_left_btn),
        .o_right_btn(o_right_btn)
    );

    assign outs = {o_right_btn, o_left_btn, o_down_btn, o_up_btn};

    always #5 i_clk = ~i_clk;

    // each step samples outputs mid-cycle, then lands 1 time unit after the next rising edge
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge i_clk);
            for (int i = 0; i < 4; i++) begin
                if (!outs[i]) begin
                    low_seen[i] = 1'b1;
                    if (i_animate && i_ani_stb) cons[i]++;
                end
            end
            if ($countones(~outs) > 1) multi++;
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic strobe_period();
        step(7);
        i_ani_stb = 1'b1;
        step(1);
        i_ani_stb = 1'b0;
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 4; i++) cons[i] = 0;
        low_seen = 4'b0000;
    endtask

    task automatic do_reset();
        i_rst     = 1'b1;
        i_up_n    = 1'b1;
        i_down_n  = 1'b1;
        i_left_n  = 1'b1;
        i_right_n = 1'b1;
        i_dead    = 1'b0;
        i_ani_stb = 1'b0;
        step(2);
        i_rst = 1'b0;
        clear_mon();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        step(2);
        n_checks++;
        if (outs !== 4'b1111) begin
            n_fail++;
            $display("FAIL reset_outs: got %b expected %b", outs, 4'b1111);
        end
        i_rst = 1'b0;
        clear_mon();
        step(10);
        n_checks++;
        if (low_seen !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_after_reset: low_seen %b expected %b", low_seen, 4'b0000);
        end
    endtask

    task automatic test_press();
        do_reset();
        i_up_n = 1'b0;
        step(6);
        n_checks++;
        if (outs !== 4'b1111) begin
            n_fail++;
            $display("FAIL press_not_early: got %b expected %b", outs, 4'b1111);
        end
        step(1);
        n_checks++;
        if (outs !== 4'b1110) begin
            n_fail++;
            $display("FAIL press_latency: got %b expected %b", outs, 4'b1110);
        end
        i_up_n = 1'b1;
        step(6);
        n_checks++;
        if (outs !== 4'b1110) begin
            n_fail++;
            $display("FAIL press_hold: got %b expected %b", outs, 4'b1110);
        end
        i_ani_stb = 1'b1;
        step(1);
        i_ani_stb = 1'b0;
        n_checks++;
        if (outs !== 4'b1111) begin
            n_fail++;
            $display("FAIL press_consumed: got %b expected %b", outs, 4'b1111);
        end
        repeat (3) strobe_period();
        n_checks++;
        if (cons[0] !== 1) begin
            n_fail++;
            $display("FAIL press_one_tick: got %0d ticks expected %0d", cons[0], 1);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            i_left_n = k[0];
            step(2);
        end
        i_left_n = 1'b1;
        step(20);
        n_checks++;
        if (low_seen[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_left_low: got %b expected %b", low_seen[2], 1'b0);
        end
        n_checks++;
        if (outs !== 4'b1111) begin
            n_fail++;
            $display("FAIL bounce_outs: got %b expected %b", outs, 4'b1111);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        i_down_n  = 1'b0;
        i_right_n = 1'b0;
        step(7);
        n_checks++;
        if (outs !== 4'b1101) begin
            n_fail++;
            $display("FAIL simul_priority: got %b expected %b", outs, 4'b1101);
        end
        i_down_n  = 1'b1;
        i_right_n = 1'b1;
        repeat (2) strobe_period();
        n_checks++;
        if (cons[1] !== 1) begin
            n_fail++;
            $display("FAIL simul_down_ticks: got %0d expected %0d", cons[1], 1);
        end
        n_checks++;
        if (low_seen[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_right_low: got %b expected %b", low_seen[3], 1'b0);
        end
    endtask

    task automatic test_repeat();
        do_reset();
        i_right_n = 1'b0;
        step(7);
        n_checks++;
        if (outs !== 4'b0111) begin
            n_fail++;
            $display("FAIL repeat_first: got %b expected %b", outs, 4'b0111);
        end
        repeat (40) strobe_period();
        n_checks++;
        if (cons[3] !== 10) begin
            n_fail++;
            $display("FAIL repeat_count: got %0d expected %0d", cons[3], 10);
        end
        n_checks++;
        if (outs !== 4'b0111) begin
            n_fail++;
            $display("FAIL repeat_pending: got %b expected %b", outs, 4'b0111);
        end
        i_right_n = 1'b1;
        repeat (3) strobe_period();
        n_checks++;
        if (cons[3] !== 11) begin
            n_fail++;
            $display("FAIL repeat_after_release: got %0d expected %0d", cons[3], 11);
        end
        n_checks++;
        if (outs !== 4'b1111) begin
            n_fail++;
            $display("FAIL repeat_released_outs: got %b expected %b", outs, 4'b1111);
        end
    endtask

    task automatic test_dead();
        do_reset();
        i_up_n = 1'b0;
        step(7);
        n_checks++;
        if (outs !== 4'b1110) begin
            n_fail++;
            $display("FAIL dead_setup: got %b expected %b", outs, 4'b1110);
        end
        i_up_n = 1'b1;
        step(5);
        i_dead = 1'b1;
        step(1);
        i_dead = 1'b0;
        n_checks++;
        if (outs !== 4'b1111) begin
            n_fail++;
            $display("FAIL dead_flush: got %b expected %b", outs, 4'b1111);
        end
        i_ani_stb = 1'b1;
        step(1);
        i_ani_stb = 1'b0;
        repeat (2) strobe_period();
        n_checks++;
        if (cons[0] !== 0) begin
            n_fail++;
            $display("FAIL dead_no_tick: got %0d expected %0d", cons[0], 0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_left_n = 1'b0;
        step(7);
        n_checks++;
        if (outs !== 4'b1011) begin
            n_fail++;
            $display("FAIL rstmid_setup: got %b expected %b", outs, 4'b1011);
        end
        i_up_n = 1'b0;
        step(4);
        i_rst = 1'b1;
        step(1);
        n_checks++;
        if (outs !== 4'b1111) begin
            n_fail++;
            $display("FAIL rstmid_outs: got %b expected %b", outs, 4'b1111);
        end
        i_rst = 1'b0;
        step(6);
        n_checks++;
        if (outs !== 4'b1111) begin
            n_fail++;
            $display("FAIL rstmid_full_debounce: got %b expected %b", outs, 4'b1111);
        end
        step(1);
        n_checks++;
        if (outs !== 4'b1110) begin
            n_fail++;
            $display("FAIL rstmid_repress: got %b expected %b", outs, 4'b1110);
        end
    endtask

    task automatic test_exclusive();
        n_checks++;
        if (multi !== 0) begin
            n_fail++;
            $display("FAIL one_hot_outputs: got %0d multi-low cycles expected %0d", multi, 0);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_press();
        test_bounce();
        test_simultaneous();
        test_repeat();
        test_dead();
        test_reset_mid();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
